// File: rtl/dds_cfg_seq.sv
`timescale 1ns/1ps
// dds_cfg_seq
// Sequencer that owns the wr_cmd serial write engine for the DDS. On init_start
// it walks an external INIT_N-entry (addr,data) table through wr_cmd. Once the
// table has completed it serves runtime frequency-tuning-word writes. Every
// completed burst is closed by an IOUP_W-cycle io_update strobe.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   init_start pulse: run the init table (accepted in idle or error only)
//   ftw_req    level: request an FTW write of ftw_in (needs init_done)
//   ftw_in     tuning word, captured when the request is accepted
//   ftw_ack    pulse: FTW written and io_update finished
//   tbl_idx    index presented to the external init table
//   tbl_addr   table register address for tbl_idx
//   tbl_data   table data for tbl_idx
//   wr_start   start pulse to wr_cmd
//   wr_addr    register address to wr_cmd, held from start to done
//   wr_din     data to wr_cmd, held from start to done
//   wr_done    wr_cmd completion pulse
//   io_update  DDS IO_UPDATE strobe
//   busy       high except in idle and error
//   init_done  sticky: init table completed
//   err        sticky: wr_done timeout, cleared by init_start
module dds_cfg_seq #(
  parameter int         INIT_N   = 4,
  parameter logic [7:0] FTW_ADDR = 8'h07,
  parameter int         IOUP_W   = 4,
  parameter int         TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  input  logic        ftw_req,
  input  logic [31:0] ftw_in,
  output logic        ftw_ack,
  output logic [3:0]  tbl_idx,
  input  logic [7:0]  tbl_addr,
  input  logic [31:0] tbl_data,
  output logic        wr_start,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_din,
  input  logic        wr_done,
  output logic        io_update,
  output logic        busy,
  output logic        init_done,
  output logic        err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = (IOUP_W > 1) ? $clog2(IOUP_W) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IOUP_LAST  = IW'(IOUP_W - 1);
  localparam logic [3:0]    LAST_IDX   = 4'(INIT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_IOUP,
    S_ERR
  } state_t;

  state_t          state_reg, state_next;
  logic            mode_ftw_reg;   // 0: init table burst, 1: runtime FTW write
  logic [TW-1:0]   timer_reg;
  logic [IW-1:0]   ioup_cnt_reg;
  logic            start_init;
  logic            accept_ftw;
  logic            next_entry;
  logic            ioup_exit;

  assign ioup_exit = (state_reg == S_IOUP) && (ioup_cnt_reg == IOUP_LAST);

  always_comb begin
    state_next = state_reg;
    start_init = 1'b0;
    accept_ftw = 1'b0;
    next_entry = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (init_start) begin
          start_init = 1'b1;
          state_next = S_LOAD;
        // ftw_ack is high in the first idle cycle after a write while the
        // requester still holds ftw_req; that level is the old request.
        end else if (ftw_req && init_done && !ftw_ack) begin
          accept_ftw = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_LOAD:  state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // wr_done is checked first so it wins over a simultaneous timeout
        if (wr_done) begin
          if (!mode_ftw_reg && (tbl_idx < LAST_IDX)) begin
            next_entry = 1'b1;
            state_next = S_LOAD;
          end else begin
            state_next = S_IOUP;
          end
        end else if (timer_reg == TIMER_LAST) begin
          state_next = S_ERR;
        end
      end
      S_IOUP: begin
        if (ioup_cnt_reg == IOUP_LAST) state_next = S_IDLE;
      end
      S_ERR: begin
        if (init_start) begin
          start_init = 1'b1;
          state_next = S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_ftw_reg <= 1'b0;
      tbl_idx      <= 4'd0;
      wr_addr      <= 8'h00;
      wr_din       <= 32'h0;
      timer_reg    <= '0;
      ioup_cnt_reg <= '0;
      init_done    <= 1'b0;
      ftw_ack      <= 1'b0;
    end else begin
      ftw_ack <= 1'b0;
      if (start_init) begin
        mode_ftw_reg <= 1'b0;
        tbl_idx      <= 4'd0;
        init_done    <= 1'b0;
      end
      if (accept_ftw) begin
        mode_ftw_reg <= 1'b1;
        wr_addr      <= FTW_ADDR;
        wr_din       <= ftw_in;
      end
      if (state_reg == S_LOAD) begin
        wr_addr <= tbl_addr;
        wr_din  <= tbl_data;
      end
      if (next_entry) tbl_idx <= tbl_idx + 4'd1;

      if (state_reg == S_ISSUE)     timer_reg <= '0;
      else if (state_reg == S_WAIT) timer_reg <= timer_reg + TW'(1);

      if (state_reg == S_IOUP) ioup_cnt_reg <= ioup_cnt_reg + IW'(1);
      else                     ioup_cnt_reg <= '0;

      if (ioup_exit) begin
        if (mode_ftw_reg) ftw_ack   <= 1'b1;
        else              init_done <= 1'b1;
      end
    end
  end

  assign wr_start  = (state_reg == S_ISSUE);
  assign io_update = (state_reg == S_IOUP);
  assign busy      = (state_reg != S_IDLE) && (state_reg != S_ERR);
  assign err       = (state_reg == S_ERR);

endmodule
